mem_wb_stage: RTL
=================

// Module: mem_wb_stage
// PURPOSE
//  MEM/WB pipeline register plus writeback select. Accepts one retiring instruction per cycle from the
//  memory stage, holds it one cycle and drives the register file write port (WEN/wsel/wdat).
//  Also owns the sticky halt flag and the retired-instruction counter.
//  Sits directly upstream of register_file. Its rf_* outputs wire straight onto the register file's write-side signals.
// PARAMETERS
//  CNT_W   32   width of retired-instruction counter (saturating)
// PORTS
//  CLK         in   1      clock, all state on posedge
//  RST         in   1      synchronous reset, active-high
//  mem_valid   in   1      memory stage presents an instruction
//  mem_ready   out  1      stage accepts this cycle (= !RST & !stall & !halt)
//  mem_regwen  in   1      instruction writes a GPR
//  mem_wsel    in   5      destination register
//  mem_wbsel   in   2      writeback source (wbsel_t)
//  mem_aluout  in   32     ALU result
//  mem_dload   in   32     load data from dcache
//  mem_npc     in   32     PC+4 (JAL link)
//  mem_imm16   in   16     immediate for LUI
//  mem_halt    in   1      instruction is HALT
//  stall       in   1      hazard unit freeze: hold entry, no write, no accept
//  flush       in   1      squash held entry and any entry offered this cycle
//  rf_wen      out  1      register file write enable
//  rf_wsel     out  5      register file write select
//  rf_wdat     out  32     register file write data
//  halt        out  1      sticky halt, to datapath/system
//  retired     out  CNT_W  instructions retired since reset
// BEHAVIOUR
//  - State: v_q, regwen_q, wsel_q, wdat_q (mux resolved at capture), halt_q, halt_sticky, cnt_q.
//  - Capture when mem_valid & mem_ready & !flush. The wbsel mux resolves at capture:
//    ALU->aluout, LOAD->dload, NPC->npc, LUI->{imm16,16'h0}.
//  - Latency: instruction offered in cycle N is written in cycle N+1 (rf commits at edge N+2) unless stalled.
//  - rf_wen = v_q & regwen_q & (wsel_q!=0) & !stall & !halt_q & !RST; rf_wsel/rf_wdat = wsel_q/wdat_q.
//  - Writes to $0 are never issued: rf_wen stays low, but the instruction still retires.
//  - Retire: v_q & !stall & !flush. cnt_q += 1 on retire, saturating at 2^CNT_W-1.
//  - Retire with no new capture clears v_q. Back-to-back retire+capture keeps v_q=1.
//  - stall: v_q and all held fields unchanged; rf_wen=0; no capture; counter unchanged.
//  - flush: v_q<=0 next cycle and rf_wen=0 this cycle. flush has priority over stall and capture.
//  - halt: retiring entry with halt_q sets halt_sticky next cycle. The HALT entry never writes.
//    Once sticky, mem_ready=0 until RST; later offers are ignored.
//  - Simultaneous stall+flush: flush wins. Simultaneous mem_valid and halt_sticky: not accepted.
//  - RST (sync): next edge v_q=0, halt_sticky=0, cnt_q=0, data fields 0.
//    During the RST cycle rf_wen=0 and mem_ready=0.
//    RST mid-stall or with a held entry discards it, with no write.
//  - Reset values: rf_wen=0, rf_wsel=0, rf_wdat=0, halt=0, retired=0, mem_ready=0 while RST.
// CONFIGURATION
//  MEM_WB_FWD_EN defined: extra outputs fwd_valid(1), fwd_sel(5), fwd_dat(32).
//    fwd_valid = v_q & regwen_q & wsel_q!=0 & !flush; fwd_sel/fwd_dat mirror wsel_q/wdat_q.
//    Decode bypasses the value before the register file commits it.
//  Undefined: ports absent; hazard unit must stall decode on a pending MEM/WB write.
// STRUCTURE
//  cpu_types_pkg: wbsel_t enum {WB_ALU=2'd0, WB_LOAD=2'd1, WB_NPC=2'd2, WB_LUI=2'd3}.
//    The package also holds the mem_wb_t packed struct (regwen, wsel, wdat, halt); word_t and regbits_t are reused.
//  Sub-module: wb_select (combinational 4:1 wbsel mux + LUI shift), instantiated at the capture input.
// TESTING
//  1 reset: RST=1 two cycles with mem_valid=1 -> rf_wen=0, retired=0, halt=0, mem_ready=0.
//  2 ALU write: wsel=5, wbsel=ALU, aluout=32'hDEADBEEF -> next cycle rf_wen=1, rf_wsel=5,
//    rf_wdat=DEADBEEF, retired=1.
//  3 mux: LUI imm16=16'h1234 -> wdat 32'h12340000. NPC npc=32'h40 -> wdat 32'h40.
//    LOAD dload=32'hA5 -> wdat 32'hA5. Also wsel=0 -> rf_wen=0 but retired still increments.
//  4 stall/flush: capture wsel=7, hold stall 3 cycles -> rf_wen=0 throughout, write once after release.
//    Then flush with a held entry -> no write, retired unchanged.
//  5 halt: HALT followed by 2 valid ALU ops -> halt=1 one cycle after HALT retires.
//    mem_ready=0 afterward, no further rf_wen, retired counts HALT.
//  6 fwd (MEM_WB_FWD_EN): held entry wsel=9 wdat=5 -> fwd_valid=1, fwd_sel=9, fwd_dat=5.
//    With flush asserted -> fwd_valid=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word/register widths, writeback source encoding and the MEM/WB entry.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_NPC  = 2'd2,
    WB_LUI  = 2'd3
  } wbsel_t;

  typedef struct packed {
    logic     regwen;
    regbits_t wsel;
    word_t    wdat;
    logic     halt;
  } mem_wb_t;

endpackage

// File: rtl/wb_select.sv
// Writeback source mux; resolves the register file data word at MEM/WB capture.
module wb_select
  import cpu_types_pkg::*;
(
  input  wbsel_t      wbsel,
  input  word_t       aluout,
  input  word_t       dload,
  input  word_t       npc,
  input  logic [15:0] imm16,
  output word_t       wdat
);

  always_comb begin
    wdat = aluout;
    unique case (wbsel)
      WB_ALU:  wdat = aluout;
      WB_LOAD: wdat = dload;
      WB_NPC:  wdat = npc;
      WB_LUI:  wdat = {imm16, 16'h0000};
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, register file write port, sticky halt and retired counter.
// Optional feature: define MEM_WB_FWD_EN to expose the held entry as a decode bypass.
module mem_wb_stage
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic             mem_regwen,
  input  logic [4:0]       mem_wsel,
  input  logic [1:0]       mem_wbsel,
  input  logic [31:0]      mem_aluout,
  input  logic [31:0]      mem_dload,
  input  logic [31:0]      mem_npc,
  input  logic [15:0]      mem_imm16,
  input  logic             mem_halt,
  input  logic             stall,
  input  logic             flush,
  output logic             rf_wen,
  output logic [4:0]       rf_wsel,
  output logic [31:0]      rf_wdat,
  output logic             halt,
`ifdef MEM_WB_FWD_EN
  output logic             fwd_valid,
  output logic [4:0]       fwd_sel,
  output logic [31:0]      fwd_dat,
`endif
  output logic [CNT_W-1:0] retired
);

  mem_wb_t          entry_q, entry_d, entry_cap;
  logic             v_q, v_d;
  logic             halt_sticky_q, halt_sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  word_t            cap_wdat;
  logic             capture, retire;

  wb_select u_wb_select (
    .wbsel  (wbsel_t'(mem_wbsel)),
    .aluout (mem_aluout),
    .dload  (mem_dload),
    .npc    (mem_npc),
    .imm16  (mem_imm16),
    .wdat   (cap_wdat)
  );

  always_comb begin
    entry_cap.regwen = mem_regwen;
    entry_cap.wsel   = mem_wsel;
    entry_cap.wdat   = cap_wdat;
    entry_cap.halt   = mem_halt;
  end

  assign mem_ready = !RST && !stall && !halt_sticky_q;
  assign capture   = mem_valid && mem_ready && !flush;
  assign retire    = v_q && !stall && !flush && !halt_sticky_q;

  always_comb begin
    v_d           = v_q;
    entry_d       = entry_q;
    halt_sticky_d = halt_sticky_q;
    cnt_d         = cnt_q;
    if (flush) begin
      v_d = 1'b0;
    end else if (!stall) begin
      if (retire) begin
        v_d = 1'b0;
        if (entry_q.halt) halt_sticky_d = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end
      // Anything accepted alongside a retiring HALT is dropped: the machine stops here.
      if (capture && !(retire && entry_q.halt)) begin
        v_d     = 1'b1;
        entry_d = entry_cap;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      v_q           <= 1'b0;
      entry_q       <= '0;
      halt_sticky_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      v_q           <= v_d;
      entry_q       <= entry_d;
      halt_sticky_q <= halt_sticky_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    rf_wen = v_q && entry_q.regwen && (entry_q.wsel != '0) && !stall && !flush &&
             !entry_q.halt && !halt_sticky_q && !RST;
  end

  assign rf_wsel = entry_q.wsel;
  assign rf_wdat = entry_q.wdat;
  assign halt    = halt_sticky_q;
  assign retired = cnt_q;

`ifdef MEM_WB_FWD_EN
  assign fwd_valid = v_q && entry_q.regwen && (entry_q.wsel != '0) && !flush;
  assign fwd_sel   = entry_q.wsel;
  assign fwd_dat   = entry_q.wdat;
`endif

endmodule
